// File: rtl/scan_ctrl_pkg.sv
// Shared types and constants for the scan chain sequencer.
package scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    CAPT   = 2'd2,
    UNLOAD = 2'd3
  } scan_state_t;

  localparam logic FILL_BIT = 1'b0;

endpackage

// File: rtl/scan_bit_counter.sv
// Loadable down-counter shared by the LOAD, CAPT and UNLOAD phases.
module scan_bit_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Terminal count is 1 so a phase of N cycles is loaded with N.
  assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Load / capture / unload sequencer for one scan chain of mux-D scan flops.
//  state  | meaning
//  IDLE   | SSEL=0, waiting for START
//  LOAD   | shifting pattern into chain, MSB first
//  CAPT   | functional clocks, SSEL=0
//  UNLOAD | shifting response out of chain tail, fill bits in
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN      = 32,
  parameter int CAPTURE_CYCLES = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic                 SDOUT,
  output logic                 SSEL,
  output logic                 SDIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP
);

  localparam int MAX_CNT = (CHAIN_LEN > CAPTURE_CYCLES) ? CHAIN_LEN : CAPTURE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] LEN_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CAP_CNT = CNT_W'(CAPTURE_CYCLES);

  scan_state_t            state_q, state_d;
  logic                   ssel_q, ssel_d;
  logic                   sdin_q, sdin_d;
  logic                   done_q, done_d;
  logic [CHAIN_LEN-1:0]   pat_sr_q, pat_sr_d;
  logic [CHAIN_LEN-2:0]   resp_sr_q, resp_sr_d;
  logic [CHAIN_LEN-1:0]   resp_q, resp_d;

  logic                   cnt_load;
  logic [CNT_W-1:0]       cnt_val;
  logic                   cnt_dec;
  logic                   cnt_last;

  scan_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .last_o     (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ssel_q    <= 1'b0;
      sdin_q    <= 1'b0;
      done_q    <= 1'b0;
      pat_sr_q  <= '0;
      resp_sr_q <= '0;
      resp_q    <= '0;
    end else begin
      state_q   <= state_d;
      ssel_q    <= ssel_d;
      sdin_q    <= sdin_d;
      done_q    <= done_d;
      pat_sr_q  <= pat_sr_d;
      resp_sr_q <= resp_sr_d;
      resp_q    <= resp_d;
    end
  end

  // ssel_d/sdin_d describe the next cycle, keeping SSEL/SDIN purely registered.
  always_comb begin
    state_d   = state_q;
    ssel_d    = 1'b0;
    sdin_d    = 1'b0;
    done_d    = 1'b0;
    pat_sr_d  = pat_sr_q;
    resp_sr_d = resp_sr_q;
    resp_d    = resp_q;
    cnt_load  = 1'b0;
    cnt_val   = LEN_CNT;
    cnt_dec   = 1'b0;

    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          state_d  = LOAD;
          ssel_d   = 1'b1;
          sdin_d   = PAT_IN[CHAIN_LEN-1];
          pat_sr_d = PAT_IN << 1;
          cnt_load = 1'b1;
          cnt_val  = LEN_CNT;
        end
      end
      LOAD: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d  = CAPT;
          cnt_load = 1'b1;
          cnt_val  = CAP_CNT;
        end else begin
          ssel_d   = 1'b1;
          sdin_d   = pat_sr_q[CHAIN_LEN-1];
          pat_sr_d = pat_sr_q << 1;
          cnt_dec  = 1'b1;
        end
      end
      CAPT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (cnt_last) begin
          state_d  = UNLOAD;
          ssel_d   = 1'b1;
          sdin_d   = FILL_BIT;
          cnt_load = 1'b1;
          cnt_val  = LEN_CNT;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      UNLOAD: begin
        if (ABORT) begin
          state_d = IDLE;
        end else begin
          resp_sr_d = (CHAIN_LEN-1)'({resp_sr_q, SDOUT});
          if (cnt_last) begin
            state_d = IDLE;
            resp_d  = {resp_sr_q, SDOUT};
            done_d  = 1'b1;
          end else begin
            ssel_d  = 1'b1;
            sdin_d  = FILL_BIT;
            cnt_dec = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign SSEL = ssel_q;
  assign SDIN = sdin_q;
  assign BUSY = (state_q != IDLE);
  assign DONE = done_q;
  assign RESP = resp_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench: two controllers (capture 1 and 3) each driving an 8-flop inverting scan chain.
module tb_scan_chain_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       START2 = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] PAT_IN = 8'h00;

  logic       SSEL, SDIN, BUSY, DONE;
  logic [7:0] RESP;
  logic       SSEL2, SDIN2, BUSY2, DONE2;
  logic [7:0] RESP2;

  logic [7:0] chain1_q = 8'h00;
  logic [7:0] chain2_q = 8'h00;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 CLK = ~CLK;

  // Scan flops: SSEL=1 shifts head-to-tail, SSEL=0 loads DIN_k = ~Q_k.
  always @(posedge CLK) begin
    chain1_q <= SSEL  ? {chain1_q[6:0], SDIN}  : ~chain1_q;
    chain2_q <= SSEL2 ? {chain2_q[6:0], SDIN2} : ~chain2_q;
  end

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(1)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .PAT_IN(PAT_IN),
    .SDOUT(chain1_q[7]), .SSEL(SSEL), .SDIN(SDIN), .BUSY(BUSY), .DONE(DONE), .RESP(RESP)
  );

  scan_chain_ctrl #(.CHAIN_LEN(8), .CAPTURE_CYCLES(3)) dut3 (
    .CLK(CLK), .RST(RST), .START(START2), .ABORT(ABORT), .PAT_IN(PAT_IN),
    .SDOUT(chain2_q[7]), .SSEL(SSEL2), .SDIN(SDIN2), .BUSY(BUSY2), .DONE(DONE2), .RESP(RESP2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Starts a pass now (caller is at a negedge) and checks all 18 cycles up to DONE.
  task automatic run_pass(input logic [7:0] pat, input logic [7:0] exp_resp,
                          input bit poke, input string tag);
    logic exp_ssel;
    START  = 1'b1;
    PAT_IN = pat;
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      START = (poke && (k == 9 || k == 12)) ? 1'b1 : 1'b0;
      exp_ssel = ((k <= 8) || (k >= 10 && k <= 17)) ? 1'b1 : 1'b0;
      chk($sformatf("%s_ssel_c%0d", tag, k), SSEL, exp_ssel);
      if (k <= 8) chk($sformatf("%s_sdin_c%0d", tag, k), SDIN, pat[8-k]);
      else        chk($sformatf("%s_sdin_c%0d", tag, k), SDIN, 1'b0);
      chk($sformatf("%s_busy_c%0d", tag, k), BUSY, (k <= 17) ? 1'b1 : 1'b0);
      chk($sformatf("%s_done_c%0d", tag, k), DONE, (k == 18) ? 1'b1 : 1'b0);
    end
    chk($sformatf("%s_resp", tag), RESP, exp_resp);
  endtask

  initial begin
    int n_done;
    int first_done;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_ssel", SSEL, 1'b0);
    chk("rst_sdin", SDIN, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_resp", RESP, 8'h00);

    // 1: basic pass
    run_pass(8'hA5, 8'h5A, 1'b0, "t1");
    @(negedge CLK);
    chk("t1_idle_done", DONE, 1'b0);
    chk("t1_idle_busy", BUSY, 1'b0);

    // 3: abort in LOAD cycle 4
    START = 1'b1; PAT_IN = 8'h3C;
    @(negedge CLK); START = 1'b0;
    repeat (3) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK); ABORT = 1'b0;
    chk("t3_busy", BUSY, 1'b0);
    chk("t3_ssel", SSEL, 1'b0);
    chk("t3_sdin", SDIN, 1'b0);
    n_done = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK);
      if (DONE) n_done++;
    end
    chk("t3_no_done", n_done, 0);
    chk("t3_resp_kept", RESP, 8'h5A);

    // 2: back-to-back passes, second START in the DONE cycle
    run_pass(8'h01, 8'hFE, 1'b0, "t2a");
    run_pass(8'h80, 8'h7F, 1'b0, "t2b");

    // 4: START pulsed during CAPT and UNLOAD is ignored
    @(negedge CLK);
    run_pass(8'h0F, 8'hF0, 1'b1, "t4");
    n_done = 0;
    for (int k = 0; k < 22; k++) begin
      @(negedge CLK);
      if (DONE) n_done++;
      if (BUSY) n_done += 100;
    end
    chk("t4_no_extra_pass", n_done, 0);

    // 5: reset during UNLOAD
    START = 1'b1; PAT_IN = 8'h33;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      START = 1'b0;
    end
    RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    chk("t5_ssel", SSEL, 1'b0);
    chk("t5_sdin", SDIN, 1'b0);
    chk("t5_busy", BUSY, 1'b0);
    chk("t5_done", DONE, 1'b0);
    chk("t5_resp", RESP, 8'h00);
    run_pass(8'hC3, 8'h3C, 1'b0, "t5b");

    // 6: START and ABORT together in IDLE
    @(negedge CLK);
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    chk("t6_busy", BUSY, 1'b0);
    chk("t6_ssel", SSEL, 1'b0);
    @(negedge CLK);
    chk("t6_busy2", BUSY, 1'b0);
    chk("t6_ssel2", SSEL, 1'b0);

    // CAPTURE_CYCLES=3 instance
    START2 = 1'b1; PAT_IN = 8'hA5;
    first_done = 0;
    for (int k = 1; k <= 25; k++) begin
      @(negedge CLK);
      START2 = 1'b0;
      if (k == 10) chk("c3_ssel_capt", SSEL2, 1'b0);
      if (k == 12) chk("c3_ssel_unload", SSEL2, 1'b1);
      if (DONE2 && first_done == 0) first_done = k;
    end
    chk("c3_done_cycle", first_done, 20);
    chk("c3_resp", RESP2, 8'h5A);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
